uart_tx_flow: RTL
=================

UART_TX_FLOW -- requirements
Module: uart_tx_flow

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the FIFO word width; legal range 5..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the TX FIFO depth; power of 2, at least 2.
REQ-003 SHALL have parameter DIV_W, default 16, meaning the baud divisor width.
REQ-004 SHALL have parameter OVERSAMPLE, default 16, meaning baud ticks per bit.
REQ-005 SHALL use one clock and an asynchronous active-low reset, with these ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
REQ-006 SHALL have these remaining ports (name, direction, width, meaning):
- tx_write  in  1  one-cycle push strobe
- tx_data  in  DATA_W  word to push
- divisor  in  DIV_W  baud divisor; 0 halts the baud generator
- data_bits  in  2  character length: 00=5, 01=6, 10=7, 11=8
- parity_en  in  1  enable parity bit
- parity_even  in  1  1=even parity, 0=odd parity
- stop2  in  1  two stop bits
- break_en  in  1  force line low
- cts_n  in  1  asynchronous clear-to-send, active low
- tx_reset  in  1  synchronous flush and abort
- stx_o  out  1  serial output
- tf_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- tf_full  out  1  FIFO full
- tf_empty  out  1  FIFO empty
- tx_idle  out  1  FIFO empty and FSM in IDLE
- tf_overrun  out  1  one-cycle pulse on a dropped write

Function
REQ-007 SHALL produce a baud tick as a one-cycle pulse every `divisor` clocks:
- down-counter reloads divisor-1 when it reaches 0;
- divisor=0 produces no ticks, and the counter holds at 0;
- a new divisor takes effect at the next reload.
REQ-008 SHALL define one bit period as exactly OVERSAMPLE ticks, counted by a bit-phase counter.
REQ-009 SHALL pass cts_n through a 2-flop synchroniser (reset value 1) before use.
REQ-010 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-011 IDLE->START SHALL occur on a tick when FIFO is non-empty, synced CTS is low and break_en=0; the same cycle pops the FIFO head into a shift register.
REQ-012 START SHALL drive 0 for one bit period, then go to DATA.
REQ-013 DATA SHALL send data_bits+5 bits LSB first, then go to PARITY if parity_en=1, otherwise STOP.
REQ-014 PARITY SHALL send the XOR of the sent bits; the bit is inverted when parity_even=0 (odd parity).
REQ-015 STOP SHALL drive 1 for 1 bit period (2 periods if stop2=1), then return to IDLE.
REQ-016 SHALL sample line-format inputs at frame start; changes mid-frame have no effect on that frame.
REQ-017 CTS deassertion mid-frame SHALL let the current frame complete; the next frame is held until CTS is low again.
REQ-018 break_en=1 SHALL force stx_o=0 regardless of state while the FSM keeps running; a new frame is not started while break_en=1.
REQ-019 A push on tx_write SHALL be visible in tf_count on the next cycle.
REQ-020 tx_write while full without a same-cycle pop SHALL drop the word, pulse tf_overrun for 1 cycle and leave count unchanged.
REQ-021 tx_write while full with a same-cycle pop SHALL accept the word, leave count unchanged and not pulse tf_overrun.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 tx_reset=1 SHALL, on the next cycle: empty the FIFO, set the FSM to IDLE, clear the bit counters and drive stx_o=1; a tx_write in the same cycle is ignored.
REQ-024 stx_o SHALL be registered, giving one cycle of latency from a state change to the line.

Reset
REQ-025 rst_n low SHALL asynchronously set:
- stx_o=1, tf_count=0, tf_empty=1, tf_full=0, tx_idle=1, tf_overrun=0;
- FSM=IDLE, all counters=0, cts synchroniser=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further line activity until a new push occurs.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state enum;
- the data_bits encoding constants;
- a function returning the bit count from data_bits.
REQ-028 SHALL instantiate one sub-module, uart_sync_fifo (parametrised by DATA_W and FIFO_DEPTH, with push/pop/count/full/empty), reusable by the future receiver.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- divisor=1, OVERSAMPLE=16, 8N1, push 0xA5, CTS low -> stx_o: start 0, bits 1,0,1,0,0,1,0,1, stop 1; each bit 16 clk; frame 160 clk; tx_idle=1 afterwards.
- 7E2, push 0x41 -> 7 data bits, parity bit=0, two stop bits, frame 11 bit periods.
- Fill 16 words, push a 17th without a pop -> tf_overrun pulses once, tf_count stays 16; the 17th word is never transmitted.
- CTS high, push 3 words -> stx_o stays 1; release CTS -> 3 frames sent back-to-back; raise CTS mid-frame 2 -> frame 2 completes, frame 3 waits.
- tx_reset during DATA bit 3 with 5 words queued -> next cycle stx_o=1, tf_count=0, tx_idle=1.
- rst_n pulsed low mid-frame -> all outputs return to their reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/uart_tx_flow_pkg.sv
// Shared definitions for the UART transmit path: FSM states, character-length
// encodings and a helper that turns the data_bits field into a bit count.
package uart_tx_flow_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;

  function automatic logic [3:0] char_bits(input logic [1:0] db);
    case (db)
      DB_5:    return 4'd5;
      DB_6:    return 4'd6;
      DB_7:    return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a show-ahead head word; a push while full is accepted
// only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_flow.sv
// UART transmitter with TX FIFO, programmable baud divisor, CTS flow control,
// break generation and synchronous flush.
module uart_tx_flow
  import uart_tx_flow_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_write,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic [DIV_W-1:0]              divisor,
  input  logic [1:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          parity_even,
  input  logic                          stop2,
  input  logic                          break_en,
  input  logic                          cts_n,
  input  logic                          tx_reset,
  output logic                          stx_o,
  output logic [$clog2(FIFO_DEPTH):0]   tf_count,
  output logic                          tf_full,
  output logic                          tf_empty,
  output logic                          tx_idle,
  output logic                          tf_overrun
);

  localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [DIV_W-1:0]  baud_cnt_reg;
  logic              tick;
  logic              cts_s1_reg, cts_s2_reg;
  logic              overrun_reg;
  logic              pop;
  logic [DATA_W-1:0] fifo_head;
  logic              bit_end;

  tx_state_t         state_reg, state_next;
  logic [PW-1:0]     phase_reg, phase_next;
  logic [3:0]        bit_idx_reg, bit_idx_next;
  logic [3:0]        nbits_reg, nbits_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              par_reg, par_next;
  logic              par_en_reg, par_en_next;
  logic              par_even_reg, par_even_next;
  logic              stop2_reg, stop2_next;
  logic              stx_reg, stx_next;

  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (tx_reset),
    .push     (tx_write && !tx_reset),
    .push_data(tx_data),
    .pop      (pop),
    .pop_data (fifo_head),
    .count    (tf_count),
    .full     (tf_full),
    .empty    (tf_empty)
  );

  assign tick    = (divisor != '0) && (baud_cnt_reg == '0);
  assign bit_end = tick && (phase_reg == PW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    baud_cnt_reg <= '0;
    else if (divisor == '0)        baud_cnt_reg <= '0;
    else if (baud_cnt_reg == '0)   baud_cnt_reg <= divisor - DIV_W'(1);
    else                           baud_cnt_reg <= baud_cnt_reg - DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_s1_reg  <= 1'b1;
      cts_s2_reg  <= 1'b1;
      overrun_reg <= 1'b0;
    end else begin
      cts_s1_reg  <= cts_n;
      cts_s2_reg  <= cts_s1_reg;
      overrun_reg <= tx_write && !tx_reset && tf_full && !pop;
    end
  end

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    bit_idx_next  = bit_idx_reg;
    nbits_next    = nbits_reg;
    shift_next    = shift_reg;
    par_next      = par_reg;
    par_en_next   = par_en_reg;
    par_even_next = par_even_reg;
    stop2_next    = stop2_reg;
    pop           = 1'b0;

    if (tick && state_reg != ST_IDLE)
      phase_next = bit_end ? '0 : phase_reg + PW'(1);

    case (state_reg)
      ST_IDLE: begin
        // Line format is latched here so mid-frame changes cannot corrupt the frame.
        if (tick && !tf_empty && !cts_s2_reg && !break_en) begin
          pop           = 1'b1;
          state_next    = ST_START;
          shift_next    = fifo_head;
          par_next      = 1'b0;
          nbits_next    = char_bits(data_bits);
          par_en_next   = parity_en;
          par_even_next = parity_even;
          stop2_next    = stop2;
          phase_next    = '0;
          bit_idx_next  = '0;
        end
      end
      ST_START: if (bit_end) state_next = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          par_next   = par_reg ^ shift_reg[0];
          if (bit_idx_reg == nbits_reg - 4'd1) begin
            bit_idx_next = '0;
            state_next   = par_en_reg ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
          end
        end
      end
      ST_PARITY: if (bit_end) state_next = ST_STOP;
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_reg && bit_idx_reg == 4'd0) begin
            bit_idx_next = 4'd1;
          end else begin
            bit_idx_next = '0;
            state_next   = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (tx_reset) begin
      state_next   = ST_IDLE;
      phase_next   = '0;
      bit_idx_next = '0;
      pop          = 1'b0;
    end

    case (state_reg)
      ST_START:  stx_next = 1'b0;
      ST_DATA:   stx_next = shift_reg[0];
      ST_PARITY: stx_next = par_reg ^ ~par_even_reg;
      default:   stx_next = 1'b1;
    endcase
    if (break_en) stx_next = 1'b0;
    if (tx_reset) stx_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      phase_reg    <= '0;
      bit_idx_reg  <= '0;
      nbits_reg    <= '0;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
      par_en_reg   <= 1'b0;
      par_even_reg <= 1'b0;
      stop2_reg    <= 1'b0;
      stx_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      bit_idx_reg  <= bit_idx_next;
      nbits_reg    <= nbits_next;
      shift_reg    <= shift_next;
      par_reg      <= par_next;
      par_en_reg   <= par_en_next;
      par_even_reg <= par_even_next;
      stop2_reg    <= stop2_next;
      stx_reg      <= stx_next;
    end
  end

  assign stx_o      = stx_reg;
  assign tf_overrun = overrun_reg;
  assign tx_idle    = tf_empty && (state_reg == ST_IDLE);

endmodule
